// File: rtl/col_hist_accum.sv
// col_hist_accum: per-frame column histogram in external BRAM with frame-end peak/total scan
module col_hist_accum #(
  parameter int X_SHIFT = 3,
  parameter int XW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          pix_valid,
  input  logic          pix_fg,
  input  logic [XW-1:0] pix_x,
  output logic          busy,
  output logic          peak_valid,
  output logic [7:0]    peak_bin,
  output logic [31:0]   peak_count,
  output logic [31:0]   total_count,
  output logic          mem_cea,
  output logic          mem_wrea,
  output logic [7:0]    mem_ada,
  output logic [31:0]   mem_din,
  output logic          mem_ceb,
  output logic          mem_oce,
  output logic [7:0]    mem_adb,
  input  logic [31:0]   mem_dout
);
  typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DRAIN, SCAN, DONE} state_t;
  state_t state;
  logic [8:0] cnt;
  logic [XW-1:0] sx;
  logic [7:0] bin, p1_b, p2_b, h1_a, h2_a, run_bin, nbin, scan_k, wa;
  logic acc, clr, scan_rd, scan_ret, wr, p1_v, p2_v, h1_v, h2_v;
  logic [31:0] h1_d, h2_d, base, wd, run_max, run_tot, nmax, ntot;
  logic [32:0] tsum;
  assign sx = pix_x >> X_SHIFT;
  assign bin = sx > XW'(255) ? 8'hff : sx[7:0];
  assign acc = state == ACCUM && pix_valid && pix_fg;
  assign clr = state == CLEAR;
  assign scan_rd = state == SCAN && !cnt[8];
  assign scan_ret = state == SCAN && cnt >= 9'd2;
  assign scan_k = 8'(cnt - 9'd2);
  // Newest in-flight write wins; RAM data is stale whenever either recent write hit this bin
  assign base = h1_v && h1_a == p2_b ? h1_d : h2_v && h2_a == p2_b ? h2_d : mem_dout;
  assign wr = clr || scan_ret || p2_v;
  assign wa = clr ? cnt[7:0] : scan_ret ? scan_k : p2_b;
  assign wd = clr || scan_ret ? '0 : base == '1 ? base : base + 32'd1;
  assign mem_wrea = !reset && wr;
  assign mem_cea = mem_wrea;
  assign mem_ada = mem_wrea ? wa : '0;
  assign mem_din = mem_wrea ? wd : '0;
  assign mem_ceb = !reset && (acc || scan_rd);
  assign mem_adb = mem_ceb ? (scan_rd ? cnt[7:0] : bin) : '0;
  assign mem_oce = !reset;
  assign busy = reset || clr || state == DRAIN || state == SCAN;
  assign nmax = mem_dout > run_max ? mem_dout : run_max;
  assign nbin = mem_dout > run_max ? scan_k : run_bin;
  assign tsum = {1'b0, run_tot} + {1'b0, mem_dout};
  assign ntot = tsum[32] ? '1 : tsum[31:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt <= '0;
      p1_v <= 1'b0;
      p2_v <= 1'b0;
      h1_v <= 1'b0;
      h2_v <= 1'b0;
      peak_valid <= 1'b0;
      peak_bin <= '0;
      peak_count <= '0;
      total_count <= '0;
      run_max <= '0;
      run_bin <= '0;
      run_tot <= '0;
    end else begin
      p1_v <= acc;
      p1_b <= bin;
      p2_v <= p1_v;
      p2_b <= p1_b;
      h1_v <= wr;
      h1_a <= wa;
      h1_d <= wd;
      h2_v <= h1_v;
      h2_a <= h1_a;
      h2_d <= h1_d;
      peak_valid <= 1'b0;
      if (scan_ret) begin
        run_max <= nmax;
        run_bin <= nbin;
        run_tot <= ntot;
      end
      case (state)
        CLEAR: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd255) begin
            state <= IDLE;
            cnt <= '0;
          end
        end
        IDLE: if (frame_start) state <= ACCUM;
        ACCUM: if (frame_end) begin
          state <= DRAIN;
          cnt <= '0;
        end
        DRAIN: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd1) begin
            state <= SCAN;
            cnt <= '0;
            run_max <= '0;
            run_bin <= '0;
            run_tot <= '0;
          end
        end
        SCAN: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd257) begin
            state <= DONE;
            peak_valid <= 1'b1;
            peak_bin <= nbin;
            peak_count <= nmax;
            total_count <= ntot;
          end
        end
        DONE: state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
